// File: rtl/pipeline_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline.
// Owns the PC, issues icache reads and fills the IF/ID latch (instr + npc).
// A one-entry skid buffer catches a word that returns while decode is stalled.
// While that word is parked (HOLD), no new read is issued, so at most one
// word is ever in flight.
module pipeline_fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] IF_instr,
    output logic [31:0] IF_npc,
    output logic        IF_valid
);

    typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, pc_inc;
    logic [31:0] skid_instr, skid_instr_nxt;
    logic [31:0] skid_npc, skid_npc_nxt;
    logic        skid_valid, skid_valid_nxt;
    logic [31:0] if_instr_q, if_instr_nxt;
    logic [31:0] if_npc_q, if_npc_nxt;
    logic        if_valid_q, if_valid_nxt;

    // Sequential PC increment wraps naturally at 2^32.
    assign pc_inc   = pc + PC_STEP;
    assign imemaddr = pc;
    assign imemREN  = (state == FETCH) & ~RST;

    assign IF_instr = if_instr_q;
    assign IF_npc   = if_npc_q;
    assign IF_valid = if_valid_q;

    // Next-state and datapath: priority halt > redirect > flush > stall > normal.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        skid_instr_nxt = skid_instr;
        skid_npc_nxt   = skid_npc;
        skid_valid_nxt = skid_valid;
        if_instr_nxt   = if_instr_q;
        if_npc_nxt     = if_npc_q;
        if_valid_nxt   = if_valid_q;

        case (state)
            FETCH: begin
                if (halt) begin
                    state_nxt      = HALTED;
                    skid_valid_nxt = 1'b0;
                    {if_instr_nxt, if_npc_nxt, if_valid_nxt} = '0;
                end else if (redirect_en) begin
                    pc_nxt = redirect_pc;
                    {if_instr_nxt, if_npc_nxt, if_valid_nxt} = '0;
                end else if (flush) begin
                    // Returning word is dropped; same PC is fetched again.
                    {if_instr_nxt, if_npc_nxt, if_valid_nxt} = '0;
                end else if (stall) begin
                    if (ihit) begin
                        skid_instr_nxt = imemload;
                        skid_npc_nxt   = pc_inc;
                        skid_valid_nxt = 1'b1;
                        pc_nxt         = pc_inc;
                        state_nxt      = HOLD;
                    end
                end else if (ihit) begin
                    if_instr_nxt = imemload;
                    if_npc_nxt   = pc_inc;
                    if_valid_nxt = 1'b1;
                    pc_nxt       = pc_inc;
                end else begin
                    {if_instr_nxt, if_npc_nxt, if_valid_nxt} = '0;
                end
            end
            HOLD: begin
                if (halt) begin
                    state_nxt      = HALTED;
                    skid_valid_nxt = 1'b0;
                    {if_instr_nxt, if_npc_nxt, if_valid_nxt} = '0;
                end else if (redirect_en) begin
                    pc_nxt         = redirect_pc;
                    skid_valid_nxt = 1'b0;
                    state_nxt      = FETCH;
                    {if_instr_nxt, if_npc_nxt, if_valid_nxt} = '0;
                end else if (flush) begin
                    // Rewind to the parked word's own address so it is refetched.
                    pc_nxt         = skid_npc - PC_STEP;
                    skid_valid_nxt = 1'b0;
                    state_nxt      = FETCH;
                    {if_instr_nxt, if_npc_nxt, if_valid_nxt} = '0;
                end else if (!stall) begin
                    if_instr_nxt   = skid_instr;
                    if_npc_nxt     = skid_npc;
                    if_valid_nxt   = 1'b1;
                    skid_valid_nxt = 1'b0;
                    state_nxt      = FETCH;
                end
            end
            default: begin
                // HALTED: everything frozen until reset.
                state_nxt = HALTED;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            skid_instr <= '0;
            skid_npc   <= '0;
            skid_valid <= 1'b0;
            if_instr_q <= '0;
            if_npc_q   <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            skid_instr <= skid_instr_nxt;
            skid_npc   <= skid_npc_nxt;
            skid_valid <= skid_valid_nxt;
            if_instr_q <= if_instr_nxt;
            if_npc_q   <= if_npc_nxt;
            if_valid_q <= if_valid_nxt;
        end
    end

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Bench for pipeline_fetch_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the fetch rules.
module tb_pipeline_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST, ihit, stall, flush, redirect_en, halt;
    logic [31:0] imemload, redirect_pc;
    logic        imemREN, IF_valid;
    logic [31:0] imemaddr, IF_instr, IF_npc;

    always #5 CLK = ~CLK;

    pipeline_fetch_stage dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall), .flush(flush),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt(halt),
        .IF_instr(IF_instr), .IF_npc(IF_npc), .IF_valid(IF_valid)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: pc, a parked-word queue (depth <= 1), halted flag, latch.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] mq_instr[$];
    logic [31:0] mq_npc[$];
    bit          m_halted = 1'b0;
    logic [31:0] m_instr = 32'h0, m_npc = 32'h0;
    logic        m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        m_instr = 0; m_npc = 0; m_valid = 0;
    endtask

    task automatic model_edge();
        if (RST) begin
            m_pc = 0; mq_instr.delete(); mq_npc.delete(); m_halted = 0; bubble();
        end else if (m_halted) begin
            // frozen
        end else if (halt) begin
            m_halted = 1; mq_instr.delete(); mq_npc.delete(); bubble();
        end else if (mq_instr.size() == 0) begin
            if (redirect_en) begin
                m_pc = redirect_pc; bubble();
            end else if (flush) begin
                bubble();
            end else if (stall) begin
                if (ihit) begin
                    mq_instr.push_back(imemload); mq_npc.push_back(m_pc + 4);
                    m_pc = m_pc + 4;
                end
            end else if (ihit) begin
                m_instr = imemload; m_npc = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
            end else begin
                bubble();
            end
        end else begin
            if (redirect_en) begin
                m_pc = redirect_pc; mq_instr.delete(); mq_npc.delete(); bubble();
            end else if (flush) begin
                m_pc = mq_npc[0] - 4; mq_instr.delete(); mq_npc.delete(); bubble();
            end else if (!stall) begin
                m_instr = mq_instr.pop_front(); m_npc = mq_npc.pop_front(); m_valid = 1;
            end
        end
    endtask

    // One clock: check address/enable before the edge, latch after it.
    task automatic cycle();
        #1;
        chk("imemaddr", imemaddr, m_pc);
        chk("imemREN", {31'b0, imemREN},
            {31'b0, (!RST && !m_halted && mq_instr.size() == 0)});
        @(posedge CLK);
        model_edge();
        #1;
        chk("IF_instr", IF_instr, m_instr);
        chk("IF_npc", IF_npc, m_npc);
        chk("IF_valid", {31'b0, IF_valid}, {31'b0, m_valid});
    endtask

    task automatic idle();
        RST = 0; ihit = 0; stall = 0; flush = 0; redirect_en = 0; halt = 0;
        imemload = 0; redirect_pc = 0;
    endtask

    task automatic do_reset();
        idle(); RST = 1; cycle(); RST = 0;
    endtask

    initial begin
        idle();
        @(posedge CLK); #1;

        // Reset state
        do_reset();
        chk("rst_valid", {31'b0, IF_valid}, 32'd0);
        chk("rst_addr", imemaddr, 32'h0);

        // 1: back-to-back fetch
        for (int i = 0; i < 3; i++) begin
            ihit = 1; imemload = 32'h2001_0001 + i * 32'h0001_0001;
            cycle();
            chk("t1_npc", IF_npc, 32'(4 * (i + 1)));
            chk("t1_instr", IF_instr, 32'h2001_0001 + i * 32'h0001_0001);
        end

        // 2: stall with ihit at pc=0x4 parks the word
        do_reset();
        ihit = 1; imemload = 32'h1111_0000; cycle();
        stall = 1; imemload = 32'hAAAA_0000; cycle();
        chk("t2_held_npc", IF_npc, 32'h4);
        ihit = 0; cycle();
        chk("t2_ren_hold", {31'b0, imemREN}, 32'd0);
        stall = 0; cycle();
        chk("t2_instr", IF_instr, 32'hAAAA_0000);
        chk("t2_npc", IF_npc, 32'h8);
        chk("t2_resume", imemaddr, 32'h8);

        // 3: redirect coincident with ihit
        ihit = 1; imemload = 32'hDEAD_BEEF; redirect_en = 1; redirect_pc = 32'h100;
        cycle();
        chk("t3_valid", {31'b0, IF_valid}, 32'd0);
        chk("t3_addr", imemaddr, 32'h100);
        redirect_en = 0;

        // 4: flush at pc=0x10 then refetch same word
        redirect_en = 1; redirect_pc = 32'h10; ihit = 0; cycle(); redirect_en = 0;
        flush = 1; ihit = 1; imemload = 32'hF1F1_0010; cycle(); flush = 0;
        chk("t4_addr", imemaddr, 32'h10);
        cycle();
        chk("t4_instr", IF_instr, 32'hF1F1_0010);
        chk("t4_npc", IF_npc, 32'h14);

        // 5: halt is sticky
        halt = 1; cycle(); halt = 0;
        for (int i = 0; i < 4; i++) begin
            ihit = 1; stall = 0; redirect_en = i[0]; redirect_pc = 32'h200; imemload = $urandom;
            cycle();
        end
        chk("t5_valid", {31'b0, IF_valid}, 32'd0);
        do_reset();
        ihit = 1; imemload = 32'h3333_0000; cycle();
        chk("t5_restart", IF_npc, 32'h4);

        // 6: reset while HOLD with a parked word
        stall = 1; imemload = 32'h6666_0000; cycle();
        RST = 1; cycle(); RST = 0;
        stall = 0; ihit = 0; cycle();
        chk("t6_valid", {31'b0, IF_valid}, 32'd0);
        chk("t6_addr", imemaddr, 32'h0);

        // PC wrap at 2^32
        redirect_en = 1; redirect_pc = 32'hFFFF_FFFC; cycle(); redirect_en = 0;
        ihit = 1; imemload = 32'h7777_0000; cycle();
        chk("wrap_npc", IF_npc, 32'h0);
        chk("wrap_pc", imemaddr, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            RST         = ($urandom_range(0, 59) == 0);
            halt        = ($urandom_range(0, 79) == 0);
            redirect_en = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            stall       = ($urandom_range(0, 2) == 0);
            ihit        = ($urandom_range(0, 3) != 0);
            imemload    = $urandom;
            redirect_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            // Leave halt for a while, then reset out of it.
            if (m_halted && $urandom_range(0, 7) == 0) RST = 1;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        n_fails++;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
